// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO access scheduler.
// Optional statistics counters are enabled with the FIFO_SCHED_STAT_EN macro.
package fifo_sched_pkg;

  // Command issued to the FIFO port in a given cycle.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_e;

  // Width and ceiling of the stall statistics counters.
  localparam int              STAT_W   = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating increment for the stall counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping N-1 -> 0) and reports the pointer value that follows the
// winner. The pointer register itself lives in the instantiating module.
module rr_arb #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  logic          found;
  logic [PW-1:0] idx;
  int            sum;

  // Scan requesters in rotated order starting at ptr; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    sum      = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr) + i;
      if (sum >= N) sum -= N;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (sum == N - 1) ? '0 : PW'(sum + 1);
      end
    end
  end

endmodule

// File: rtl/fifo_access_sched.sv
// Access scheduler for a single-port sync FIFO: arbitrates NUM_WR producers
// round-robin on the write side, serves one reader, picks one command per
// cycle and returns read data with a valid strobe after RD_LAT cycles.
// Define FIFO_SCHED_STAT_EN to add stall counters (stat_clr, full_stall_cnt,
// empty_stall_cnt); scheduling is identical with or without it.
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_WR   = 4,
  parameter int ADR_BIT  = 6,
  parameter int DAT_BIT  = 32,
  parameter int RD_LAT   = 1,
  parameter int AFULL_TH = 56
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_WR-1:0]         wr_req,
  input  logic [NUM_WR*DAT_BIT-1:0] wr_dat_i,
  output logic [NUM_WR-1:0]         wr_gnt,
  input  logic                      rd_req,
  output logic                      rd_gnt,
  output logic                      rd_vld,
  output logic [DAT_BIT-1:0]        rd_dat_o,
  output logic                      cs_en,
  output logic                      wr_en,
  output logic [DAT_BIT-1:0]        wr_dat,
  input  logic [DAT_BIT-1:0]        rd_dat,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic [ADR_BIT:0]          fifo_count
`ifdef FIFO_SCHED_STAT_EN
  ,
  input  logic                      stat_clr,
  output logic [STAT_W-1:0]         full_stall_cnt,
  output logic [STAT_W-1:0]         empty_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [NUM_WR-1:0] arb_gnt;
  logic              we;
  logic              re;
  logic              afull;
  op_e               op;
  op_e               last_op;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] vld_next;

  rr_arb #(.N(NUM_WR)) u_rr_arb (
    .req      (wr_req),
    .ptr      (ptr),
    .gnt      (arb_gnt),
    .next_ptr (next_ptr)
  );

  assign we    = (|wr_req) & ~fifo_full;
  assign re    = rd_req & ~fifo_empty;
  assign afull = fifo_count >= (ADR_BIT + 1)'(AFULL_TH);

  // Pick this cycle's command; reads win near-full, otherwise alternate on
  // conflict. Held off while in reset so no command leaks out during reset.
  always_comb begin
    op = OP_NONE;
    if (rst_n) begin
      if (re && we)  op = (afull || last_op == OP_WR) ? OP_RD : OP_WR;
      else if (re)   op = OP_RD;
      else if (we)   op = OP_WR;
    end
  end

  // Drive the FIFO command port and the grants from the selected command.
  always_comb begin
    wr_gnt = (op == OP_WR) ? arb_gnt : '0;
    rd_gnt = (op == OP_RD);
    cs_en  = (op != OP_NONE);
    wr_en  = (op == OP_WR);
    wr_dat = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (op == OP_WR && arb_gnt[k]) wr_dat = wr_dat_i[k*DAT_BIT +: DAT_BIT];
    end
  end

  // Advance the round-robin pointer past each write winner.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)           ptr <= '0;
    else if (op == OP_WR) ptr <= next_ptr;
  end

  // Remember the last issued command for conflict alternation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_op <= OP_RD;
    else if (op != OP_NONE) last_op <= op;
  end

  // Shift-in position of the read-valid pipeline (rd_gnt enters at bit 0).
  assign vld_next = RD_LAT'({vld_pipe, rd_gnt});
  assign rd_vld   = vld_pipe[RD_LAT-1];

  // Track in-flight reads and capture FIFO data on the edge rd_vld rises;
  // reset drops any in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      rd_dat_o <= '0;
    end else begin
      vld_pipe <= vld_next;
      if (vld_next[RD_LAT-1]) rd_dat_o <= rd_dat;
    end
  end

`ifdef FIFO_SCHED_STAT_EN
  // Saturating stall counters; a clear request beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_stall_cnt  <= '0;
      empty_stall_cnt <= '0;
    end else if (stat_clr) begin
      full_stall_cnt  <= '0;
      empty_stall_cnt <= '0;
    end else begin
      if ((|wr_req) && fifo_full)  full_stall_cnt  <= sat_inc(full_stall_cnt);
      if (rd_req && fifo_empty)    empty_stall_cnt <= sat_inc(empty_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed bench for fifo_access_sched with a behavioural FIFO and a read
// scoreboard. Built with RD_LAT=3; FIFO_SCHED_STAT_EN adds counter checks.
module tb_fifo_access_sched;
  import fifo_sched_pkg::*;

  localparam int NUM_WR   = 4;
  localparam int ADR_BIT  = 6;
  localparam int DAT_BIT  = 32;
  localparam int RD_LAT   = 3;
  localparam int AFULL_TH = 56;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_WR-1:0]         wr_req;
  logic [NUM_WR*DAT_BIT-1:0] wr_dat_i;
  logic [NUM_WR-1:0]         wr_gnt;
  logic                      rd_req;
  logic                      rd_gnt;
  logic                      rd_vld;
  logic [DAT_BIT-1:0]        rd_dat_o;
  logic                      cs_en;
  logic                      wr_en;
  logic [DAT_BIT-1:0]        wr_dat;
  logic [DAT_BIT-1:0]        rd_dat;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ADR_BIT:0]          fifo_count;
`ifdef FIFO_SCHED_STAT_EN
  logic                      stat_clr;
  logic [STAT_W-1:0]         full_stall_cnt;
  logic [STAT_W-1:0]         empty_stall_cnt;
`endif

  logic [DAT_BIT-1:0] drv [NUM_WR];
  assign wr_dat_i = {drv[3], drv[2], drv[1], drv[0]};

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  fifo_access_sched #(
    .NUM_WR(NUM_WR), .ADR_BIT(ADR_BIT), .DAT_BIT(DAT_BIT),
    .RD_LAT(RD_LAT), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_dat_i(wr_dat_i),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_vld(rd_vld),
    .rd_dat_o(rd_dat_o), .cs_en(cs_en), .wr_en(wr_en), .wr_dat(wr_dat),
    .rd_dat(rd_dat), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count)
`ifdef FIFO_SCHED_STAT_EN
    , .stat_clr(stat_clr), .full_stall_cnt(full_stall_cnt),
    .empty_stall_cnt(empty_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: 64 deep, read data emerges RD_LAT-1 cycles after the
  // command edge so the DUT captures it on the edge rd_vld rises.
  logic [DAT_BIT-1:0] mem [64];
  logic [5:0]         wp = '0;
  logic [5:0]         rp = '0;
  logic [6:0]         cnt = '0;
  logic [DAT_BIT-1:0] line1 = '0;
  logic [DAT_BIT-1:0] line2 = '0;

  assign fifo_count = cnt;
  assign fifo_full  = (cnt == 7'd64);
  assign fifo_empty = (cnt == 7'd0);
  assign rd_dat     = line2;

  always @(posedge clk) begin
    line1 <= mem[rp];
    line2 <= line1;
    if (cs_en && wr_en && cnt != 7'd64) begin
      mem[wp] <= wr_dat;
      wp      <= wp + 6'd1;
      cnt     <= cnt + 7'd1;
    end else if (cs_en && !wr_en && cnt != 7'd0) begin
      rp  <= rp + 6'd1;
      cnt <= cnt - 7'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: written words queue up in order; each read grant moves the
  // head word into the pending list with the cycle its rd_vld is due.
  logic [DAT_BIT-1:0] exp_q [$];
  logic [DAT_BIT-1:0] pend_dat [$];
  int                 pend_due [$];
  logic [DAT_BIT-1:0] last_dat = '0;
  int                 mon_idx;

  always @(negedge clk) begin
    check("gnt_onehot", $onehot0(wr_gnt), 1);
    check("gnt_excl", (|wr_gnt) & rd_gnt, 0);
    check("cs_en", cs_en, (|wr_gnt) | rd_gnt);
    check("wr_en", wr_en, |wr_gnt);
    if (fifo_full)  check("no_wr_when_full", wr_gnt, 0);
    if (fifo_empty) check("no_rd_when_empty", rd_gnt, 0);
    if (!rst_n) begin
      last_dat = '0;
    end else begin
      if (rd_vld) begin
        check("vld_expected", pend_due.size() != 0, 1);
        if (pend_due.size() != 0) begin
          check("vld_cycle", cyc, pend_due.pop_front());
          last_dat = pend_dat.pop_front();
          check("vld_data", rd_dat_o, last_dat);
        end
      end else begin
        check("rd_hold", rd_dat_o, last_dat);
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
          check("vld_missing", rd_vld, 1);
          void'(pend_due.pop_front());
          void'(pend_dat.pop_front());
        end
      end
      if (|wr_gnt) begin
        mon_idx = 0;
        for (int k = 0; k < NUM_WR; k++) if (wr_gnt[k]) mon_idx = k;
        check("wr_dat", wr_dat, drv[mon_idx]);
        exp_q.push_back(drv[mon_idx]);
      end
      if (rd_gnt) begin
        check("rd_model_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          pend_dat.push_back(exp_q.pop_front());
          pend_due.push_back(cyc + RD_LAT);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_wr_gnt"},   wr_gnt, 0);
    check({tag, "_rd_gnt"},   rd_gnt, 0);
    check({tag, "_rd_vld"},   rd_vld, 0);
    check({tag, "_rd_dat_o"}, rd_dat_o, 0);
    check({tag, "_cs_en"},    cs_en, 0);
    check({tag, "_wr_en"},    wr_en, 0);
    check({tag, "_wr_dat"},   wr_dat, 0);
  endtask

  // Bench model of occupancy and last command for conflict expectations.
  int  cnt_m;
  op_e last_m;

  task automatic conflict_run(input int n);
    logic exp_rd;
    rd_req = 1'b1;
    wr_req = 4'b0100;
    for (int i = 0; i < n; i++) begin
      exp_rd = (cnt_m >= AFULL_TH) || (last_m == OP_WR);
      @(negedge clk);
      check("conf_rd_gnt", rd_gnt, exp_rd);
      check("conf_wr_gnt", wr_gnt, exp_rd ? 4'b0000 : 4'b0100);
      if (exp_rd) begin cnt_m--; last_m = OP_RD; end
      else        begin cnt_m++; last_m = OP_WR; end
      tick();
      drv[2] = drv[2] + 1;
    end
    rd_req = 1'b0;
    wr_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b1;
    wr_req = '0;
    rd_req = 1'b0;
    for (int k = 0; k < NUM_WR; k++) drv[k] = '0;
`ifdef FIFO_SCHED_STAT_EN
    stat_clr = 1'b0;
`endif
    #2 rst_n = 1'b0;
    wr_req = 4'b1111;           // requests during reset must stay ungranted
    tick();
    check_idle("reset");
    tick();
    wr_req = '0;
    rst_n  = 1'b1;

    // Fill from requester 0 with 0..63, then hit full.
    for (int n = 0; n < 64; n++) begin
      drv[0] = n;
      wr_req = 4'b0001;
      @(negedge clk);
      check("fill_gnt", wr_gnt, 4'b0001);
      tick();
    end
    drv[0] = 64;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("full_flag", fifo_full, 1);
      check("full_gnt", wr_gnt, 0);
`ifdef FIFO_SCHED_STAT_EN
      check("full_stall_cnt", full_stall_cnt, j);
`endif
      tick();
    end
    wr_req = '0;

    // Drain with rd_req held 70 cycles: 64 grants, then nothing.
    rd_req = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("drain_rd_gnt", rd_gnt, i < 64);
      tick();
    end
    rd_req = 1'b0;
`ifdef FIFO_SCHED_STAT_EN
    @(negedge clk);
    check("empty_stall_cnt", empty_stall_cnt, 6);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    check("clr_full_cnt", full_stall_cnt, 0);
    check("clr_empty_cnt", empty_stall_cnt, 0);
    tick();
`endif
    check("drain_pending", pend_due.size(), 0);

    // Reset one cycle after a read grant: the in-flight read must vanish.
    drv[2] = 32'hA5A5_0001;
    wr_req = 4'b0100;
    @(negedge clk);
    check("pre_rst_wr", wr_gnt, 4'b0100);
    tick();
    wr_req = '0;
    rd_req = 1'b1;
    @(negedge clk);
    check("pre_rst_rd", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    for (int k = 0; k < NUM_WR; k++) drv[k] = 32'hC0DE_0000 + k;
    wr_req = 4'b1111;
    rst_n  = 1'b0;
    pend_dat.delete();
    pend_due.delete();
    check_idle("midrst");
    tick();
    rst_n = 1'b1;

    // All four requesters held: pointer restarts at 0, one grant per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_gnt", wr_gnt, 4'b0001 << (i % 4));
      tick();
    end
    wr_req = '0;
    cnt_m  = 8;

    // Top up to 10 from requester 2, then conflict at low occupancy.
    drv[2] = 32'h2000_0000;
    wr_req = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("topup_gnt", wr_gnt, 4'b0100);
      tick();
      drv[2] = drv[2] + 1;
    end
    cnt_m  = 10;
    last_m = OP_WR;
    conflict_run(8);

    // Raise occupancy to the threshold, then conflict again.
    wr_req = 4'b0100;
    while (cnt_m < AFULL_TH) begin
      @(negedge clk);
      check("raise_gnt", wr_gnt, 4'b0100);
      tick();
      drv[2] = drv[2] + 1;
      cnt_m++;
    end
    wr_req = '0;
    last_m = OP_WR;
    conflict_run(8);

    // Drain to empty.
    rd_req = 1'b1;
    while (cnt_m > 0) begin
      @(negedge clk);
      check("empty_drain_gnt", rd_gnt, 1);
      tick();
      cnt_m--;
    end
    rd_req = 1'b0;

    // Empty FIFO with simultaneous read and write: write first, read next.
    drv[1] = 32'hBEEF_0001;
    rd_req = 1'b1;
    wr_req = 4'b0010;
    @(negedge clk);
    check("empty_sim_wr", wr_gnt, 4'b0010);
    check("empty_sim_rd", rd_gnt, 0);
    tick();
    wr_req = '0;
    @(negedge clk);
    check("empty_next_rd", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    repeat (RD_LAT + 3) tick();
    check("final_pending", pend_due.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
